// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: grants up to NUM_LANES result sources per cycle
// with rotating priority plus starvation override, and registers winners onto the CDB.
module cdb_arbiter #(
  parameter int NUM_REQ      = 6,
  parameter int NUM_LANES    = 3,
  parameter int TAG_W        = 6,
  parameter int ROB_W        = 5,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
  input  logic [NUM_REQ*ROB_W-1:0]    req_rob_idx,
  input  logic [NUM_REQ*DATA_W-1:0]   req_value,
  output logic [NUM_REQ-1:0]          req_grant,
  output logic [NUM_LANES-1:0]        cdb_valid,
  output logic [NUM_LANES*TAG_W-1:0]  cdb_tag,
  output logic [NUM_LANES*ROB_W-1:0]  cdb_rob_idx,
  output logic [NUM_LANES*DATA_W-1:0] cdb_value,
  output logic [NUM_REQ-1:0]          starved
);
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IDX_W  = PTR_W + 1;
  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam int LANE_W = $clog2(NUM_LANES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [PTR_W-1:0]  rr_ptr, rr_next, last_idx, sel;
  logic [IDX_W-1:0]  idx;
  logic [LANE_W-1:0] n_grant;
  logic [CNT_W-1:0]  wait_cnt [NUM_REQ];
  logic [TAG_W-1:0]  tag_a [NUM_REQ];
  logic [ROB_W-1:0]  rob_a [NUM_REQ];
  logic [DATA_W-1:0] val_a [NUM_REQ];
  logic [PTR_W-1:0]  lane_src [NUM_LANES];
  logic [NUM_LANES-1:0] lane_hit;
  logic [TAG_W-1:0]  lane_tag_q [NUM_LANES];
  logic [ROB_W-1:0]  lane_rob_q [NUM_LANES];
  logic [DATA_W-1:0] lane_val_q [NUM_LANES];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign tag_a[i]   = req_tag[i*TAG_W +: TAG_W];
    assign rob_a[i]   = req_rob_idx[i*ROB_W +: ROB_W];
    assign val_a[i]   = req_value[i*DATA_W +: DATA_W];
    assign starved[i] = (wait_cnt[i] == CNT_MAX);
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign cdb_tag[l*TAG_W +: TAG_W]      = lane_tag_q[l];
    assign cdb_rob_idx[l*ROB_W +: ROB_W]  = lane_rob_q[l];
    assign cdb_value[l*DATA_W +: DATA_W]  = lane_val_q[l];
  end

  // Pass 0 picks starved requesters, pass 1 the rest; both rotate from rr_ptr.
  always_comb begin
    req_grant = '0;
    lane_hit  = '0;
    n_grant   = '0;
    last_idx  = rr_ptr;
    idx       = '0;
    sel       = '0;
    for (int l = 0; l < NUM_LANES; l++) lane_src[l] = '0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = {1'b0, rr_ptr} + IDX_W'(k);
        if (idx >= IDX_W'(NUM_REQ)) idx = idx - IDX_W'(NUM_REQ);
        sel = idx[PTR_W-1:0];
        if (reset && !flush && req_valid[sel] && (starved[sel] == (pass == 0))
            && (n_grant < LANE_W'(NUM_LANES))) begin
          req_grant[sel] = 1'b1;
          for (int l = 0; l < NUM_LANES; l++) begin
            if (n_grant == LANE_W'(l)) begin
              lane_src[l] = sel;
              lane_hit[l] = 1'b1;
            end
          end
          n_grant  = n_grant + LANE_W'(1);
          last_idx = sel;
        end
      end
    end
    rr_next = (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + PTR_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr    <= '0;
      cdb_valid <= '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        lane_tag_q[l] <= '0;
        lane_rob_q[l] <= '0;
        lane_val_q[l] <= '0;
      end
    end else begin
      cdb_valid <= lane_hit;
      if (n_grant != '0) rr_ptr <= rr_next;
      for (int l = 0; l < NUM_LANES; l++) begin
        if (lane_hit[l]) begin
          lane_tag_q[l] <= tag_a[lane_src[l]];
          lane_rob_q[l] <= rob_a[lane_src[l]];
          lane_val_q[l] <= val_a[lane_src[l]];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (flush || req_grant[i] || !req_valid[i]) wait_cnt[i] <= '0;
        else if (wait_cnt[i] != CNT_MAX)          wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: grants checked inline, CDB lanes checked by a
// scoreboard monitor; a single-lane instance covers the starvation override.
module tb_cdb_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [5:0]  req_valid = '0;
  logic [35:0] req_tag = '0;
  logic [29:0] req_rob_idx = '0;
  logic [191:0] req_value = '0;
  logic [5:0]  req_grant;
  logic [2:0]  cdb_valid;
  logic [17:0] cdb_tag;
  logic [14:0] cdb_rob_idx;
  logic [95:0] cdb_value;
  logic [5:0]  starved;

  logic [5:0]  req_valid1 = '0;
  logic [5:0]  req_grant1;
  logic [0:0]  cdb_valid1;
  logic [5:0]  cdb_tag1;
  logic [4:0]  cdb_rob_idx1;
  logic [31:0] cdb_value1;
  logic [5:0]  starved1;

  logic [5:0]  p_tag [6];
  logic [4:0]  p_rob [6];
  logic [31:0] p_val [6];

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [2:0]  v;
    logic [17:0] tag;
    logic [14:0] rob;
    logic [95:0] val;
  } exp_t;
  exp_t sb[$];

  cdb_arbiter u_dut (
    .clock(clock), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_tag(req_tag), .req_rob_idx(req_rob_idx),
    .req_value(req_value), .req_grant(req_grant), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_rob_idx(cdb_rob_idx), .cdb_value(cdb_value),
    .starved(starved)
  );

  cdb_arbiter #(.NUM_LANES(1)) u_dut1 (
    .clock(clock), .reset(reset), .flush(1'b0),
    .req_valid(req_valid1), .req_tag(req_tag), .req_rob_idx(req_rob_idx),
    .req_value(req_value), .req_grant(req_grant1), .cdb_valid(cdb_valid1),
    .cdb_tag(cdb_tag1), .cdb_rob_idx(cdb_rob_idx1), .cdb_value(cdb_value1),
    .starved(starved1)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_payload();
    for (int i = 0; i < 6; i++) begin
      req_tag[i*6 +: 6]      = p_tag[i];
      req_rob_idx[i*5 +: 5]  = p_rob[i];
      req_value[i*32 +: 32]  = p_val[i];
    end
  endtask

  // One cycle on the 3-lane instance; lN is the requester expected on lane N, -1 for none.
  task automatic step(input string name, input logic [5:0] v, input logic fl,
                      input logic [5:0] eg, input int l0, input int l1, input int l2);
    int   ls [3];
    exp_t e;
    @(negedge clock);
    req_valid = v;
    flush     = fl;
    drive_payload();
    #1;
    check({name, "_grant"}, 32'(req_grant), 32'(eg));
    ls = '{l0, l1, l2};
    e  = '0;
    for (int l = 0; l < 3; l++) begin
      if (ls[l] >= 0) begin
        e.v[l]            = 1'b1;
        e.tag[l*6 +: 6]   = p_tag[ls[l]];
        e.rob[l*5 +: 5]   = p_rob[ls[l]];
        e.val[l*32 +: 32] = p_val[ls[l]];
      end
    end
    if (e.v != '0) sb.push_back(e);
  endtask

  task automatic step1(input string name, input logic [5:0] v, input logic [5:0] eg,
                       input logic [5:0] es);
    @(negedge clock);
    req_valid1 = v;
    #1;
    check({name, "_starved"}, 32'(starved1), 32'(es));
    check({name, "_grant"}, 32'(req_grant1), 32'(eg));
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (reset && cdb_valid != '0) begin
      if (sb.size() == 0) begin
        check("cdb_unexpected", 32'(cdb_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("cdb_valid", 32'(cdb_valid), 32'(e.v));
        for (int l = 0; l < 3; l++) begin
          if (e.v[l]) begin
            check($sformatf("cdb_tag%0d", l), 32'(cdb_tag[l*6 +: 6]), 32'(e.tag[l*6 +: 6]));
            check($sformatf("cdb_rob%0d", l), 32'(cdb_rob_idx[l*5 +: 5]), 32'(e.rob[l*5 +: 5]));
            check($sformatf("cdb_val%0d", l), cdb_value[l*32 +: 32], e.val[l*32 +: 32]);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 6; i++) begin
      p_tag[i] = 6'(10 + i);
      p_rob[i] = 5'(i);
      p_val[i] = 32'hA500_0000 + 32'(i);
    end
    req_valid = 6'b111111;
    drive_payload();
    #3;
    check("rst_grant", 32'(req_grant), 32'd0);
    @(negedge clock);
    check("rst_cdb_valid", 32'(cdb_valid), 32'd0);
    check("rst_starved", 32'(starved), 32'd0);
    @(posedge clock);
    #2 reset = 1'b1;

    step("v1_all", 6'b111111, 1'b0, 6'b000111, 0, 1, 2);
    step("v2_all", 6'b111111, 1'b0, 6'b111000, 3, 4, 5);
    step("v3_wrap", 6'b111111, 1'b0, 6'b000111, 0, 1, 2);
    p_tag[4] = 6'd17;
    p_val[4] = 32'hDEADBEEF;
    step("v4_single", 6'b010000, 1'b0, 6'b010000, 4, -1, -1);
    step("v5_two", 6'b100010, 1'b0, 6'b100010, 5, 1, -1);
    step("v6_idle", 6'b000000, 1'b0, 6'b000000, -1, -1, -1);
    @(posedge clock); #1;
    check("v6_cdb_valid", 32'(cdb_valid), 32'd0);
    step("v7_five", 6'b011111, 1'b0, 6'b011100, 2, 3, 4);
    step("v8_flush", 6'b011111, 1'b1, 6'b000000, -1, -1, -1);
    @(posedge clock); #1;
    check("v8_cdb_valid", 32'(cdb_valid), 32'd0);
    check("v8_starved", 32'(starved), 32'd0);
    step("v9_rr_kept", 6'b111111, 1'b0, 6'b100011, 5, 0, 1);
    step("v10_all", 6'b111111, 1'b0, 6'b011100, 2, 3, 4);
    @(posedge clock); #1;
    check("v10_cdb_full", 32'(cdb_valid), 32'd7);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("arst_cdb_valid", 32'(cdb_valid), 32'd0);
    check("arst_cdb_tag", 32'(cdb_tag), 32'd0);
    check("arst_grant", 32'(req_grant), 32'd0);
    req_valid = '0;
    flush     = 1'b0;
    @(posedge clock);
    #2 reset = 1'b1;

    step1("s_a", 6'b001000, 6'b001000, 6'b000000);
    step1("s_b", 6'b111011, 6'b010000, 6'b000000);
    step1("s_c", 6'b111011, 6'b100000, 6'b000000);
    step1("s_d", 6'b111011, 6'b000001, 6'b000000);
    step1("s_e", 6'b111011, 6'b000010, 6'b000000);
    step1("s_f", 6'b001111, 6'b001000, 6'b001000);
    step1("s_g", 6'b001111, 6'b000001, 6'b000000);

    @(negedge clock);
    req_valid1 = '0;
    @(negedge clock);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
